// File: rtl/clock_adj_pkg.sv
// -----------------------------------------------------------------------------
// clock_adj_pkg
// Shared types for the clock adjust front end: the pulse generator FSM state
// encoding and the two-bit button code {up, down} used to latch a press.
// -----------------------------------------------------------------------------
package clock_adj_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    DEBOUNCE     = 3'd1,
    HOLD         = 3'd2,
    REPEAT       = 3'd3,
    WAIT_RELEASE = 3'd4
  } adj_state_e;

  // Button code is {up_s, down_s}
  localparam logic [1:0] BTN_NONE = 2'b00;
  localparam logic [1:0] BTN_DOWN = 2'b01;
  localparam logic [1:0] BTN_UP   = 2'b10;
  localparam logic [1:0] BTN_BOTH = 2'b11;

endpackage

// File: rtl/btn_sync2.sv
// -----------------------------------------------------------------------------
// btn_sync2
// Two-flop synchroniser for one asynchronous push-button input.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst   - synchronous active-high reset, clears both flops
//   i_async - raw asynchronous input
//   o_sync  - synchronised level, two i_clk edges after the raw change
// -----------------------------------------------------------------------------
module btn_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_async;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_sync = sync_q;

endmodule

// File: rtl/adjust_pulse_gen.sv
// -----------------------------------------------------------------------------
// adjust_pulse_gen
// Drives the up/down inputs of the 0-59 counter. Two raw buttons are
// synchronised, debounced and turned into single-cycle pulses with
// hold-to-auto-repeat. While no button is active the 1 Hz run tick is
// forwarded as an up pulse.
//
// Optional feature macro: ADJ_BOTH_CLEAR_EN
//   defined   - both buttons together emit one simultaneous up+down (clear)
//   undefined - both buttons together emit nothing; FSM waits for release
//
// Ports:
//   i_clk        - clock, rising edge
//   i_rst        - synchronous active-high reset
//   i_btn_up     - raw up button (asynchronous)
//   i_btn_down   - raw down button (asynchronous)
//   i_tick       - single-cycle run tick, i_clk domain
//   i_run_en     - forward i_tick as an up pulse when idle
//   o_up         - registered single-cycle up pulse
//   o_down       - registered single-cycle down pulse
//   o_adjusting  - registered, high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module adjust_pulse_gen
  import clock_adj_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_up,
  input  logic i_btn_down,
  input  logic i_tick,
  input  logic i_run_en,
  output logic o_up,
  output logic o_down,
  output logic o_adjusting
);

  localparam int MAX_P = (DEBOUNCE_CYCLES > HOLD_CYCLES) ?
                         ((DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES) :
                         ((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
  localparam int CW = $clog2(MAX_P) + 1;

  typedef logic [CW-1:0] cnt_t;

  // Debounce counts the current sample too, so it fires one count early.
  localparam cnt_t DEB_M1 = cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam cnt_t HOLD_C = cnt_t'(HOLD_CYCLES);
  localparam cnt_t REP_C  = cnt_t'(REPEAT_CYCLES);
  localparam cnt_t ONE    = cnt_t'(1);

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + ONE;
  endfunction

  // Synchronised button code
  logic       up_s, down_s;
  logic [1:0] code;

  btn_sync2 u_sync_up (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_btn_up),
    .o_sync  (up_s)
  );

  btn_sync2 u_sync_down (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_btn_down),
    .o_sync  (down_s)
  );

  assign code = {up_s, down_s};

  adj_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] code_q, code_d;
  logic       up_q, up_d;
  logic       down_q, down_d;
  logic       adj_q, adj_d;
  logic       fire;
  logic [1:0] fire_code;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    up_d      = 1'b0;
    down_d    = 1'b0;
    fire      = 1'b0;
    fire_code = code_q;

    case (state_q)
      IDLE: begin
        if (code != BTN_NONE) begin
          // A press always wins over a tick arriving in the same cycle.
          code_d    = code;
          cnt_d     = ONE;
          state_d   = DEBOUNCE;
          fire_code = code;
          // With single-sample debounce, fire now unless a tick pulse went
          // out last cycle; then DEBOUNCE fires one cycle later instead.
          if (DEBOUNCE_CYCLES == 1 && !(up_q || down_q)) begin
            fire = 1'b1;
          end
        end else if (i_run_en && i_tick) begin
          up_d = 1'b1;
        end
      end

      DEBOUNCE: begin
        if (code != code_q) begin
          state_d = IDLE;
        end else if (cnt_q >= DEB_M1) begin
          fire = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      HOLD, REPEAT: begin
        if (code == BTN_NONE) begin
          state_d = IDLE;
        end else if (code != code_q) begin
          // Second button joining mid-hold locks out until full release.
          state_d = WAIT_RELEASE;
        end else if (cnt_q >= ((state_q == HOLD) ? HOLD_C : REP_C)) begin
          up_d    = (code_q == BTN_UP);
          down_d  = (code_q == BTN_DOWN);
          state_d = REPEAT;
          cnt_d   = ONE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      WAIT_RELEASE: begin
        if (code == BTN_NONE) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (fire) begin
      case (fire_code)
        BTN_UP: begin
          up_d    = 1'b1;
          state_d = HOLD;
          cnt_d   = ONE;
        end
        BTN_DOWN: begin
          down_d  = 1'b1;
          state_d = HOLD;
          cnt_d   = ONE;
        end
        BTN_BOTH: begin
`ifdef ADJ_BOTH_CLEAR_EN
          up_d    = 1'b1;
          down_d  = 1'b1;
`endif
          state_d = WAIT_RELEASE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    adj_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= BTN_NONE;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      adj_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      up_q    <= up_d;
      down_q  <= down_d;
      adj_q   <= adj_d;
    end
  end

  assign o_up        = up_q;
  assign o_down      = down_q;
  assign o_adjusting = adj_q;

endmodule

// File: tb/tb_adjust_pulse_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_adjust_pulse_gen
// Directed scenarios plus randomized button/tick/reset traffic. Every cycle
// the outputs are compared with a press-episode reference model; directed
// scenarios additionally compare recorded pulse times with fixed values.
// -----------------------------------------------------------------------------
module tb_adjust_pulse_gen;

  localparam int D    = 4;
  localparam int H    = 16;
  localparam int R    = 4;
  localparam int HMAX = 8192;

  // ---------------------------------------------------------------- clock/reset
  logic i_clk = 1'b0;
  logic i_rst, i_btn_up, i_btn_down, i_tick, i_run_en;
  logic o_up, o_down, o_adjusting;

  always #5 i_clk = ~i_clk;

  adjust_pulse_gen #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_btn_up    (i_btn_up),
    .i_btn_down  (i_btn_down),
    .i_tick      (i_tick),
    .i_run_en    (i_run_en),
    .o_up        (o_up),
    .o_down      (o_down),
    .o_adjusting (o_adjusting)
  );

  // ---------------------------------------------------------------- bookkeeping
  logic h_up [HMAX];
  logic h_dn [HMAX];
  logic h_tk [HMAX];
  logic h_en [HMAX];
  logic h_rs [HMAX];

  int         cyc;
  int         errors;
  int         checks;
  logic [2:0] exp_q[$];
  int         up_t[$];
  int         dn_t[$];
  int         base;
  int         adj_fall;
  logic       adj_prev;

  // Reference model: one "press episode" at a time
  bit         m_busy;
  bit         m_locked;
  logic [1:0] m_code;
  int         m_len;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Pulse owed at this many consecutive equal samples of a single button
  function automatic bit pulse_due(input int len);
    int a;
    if (len == D) return 1'b1;
    if (len < D) return 1'b0;
    a = len - D;
    return (a == H) || (a > H && ((a - H) % R) == 0);
  endfunction

  // Expected outputs right after edge k (inputs from cycle k-1)
  task automatic model_edge(input int k);
    int         p;
    logic [1:0] c;
    logic       eu, ed;
    p  = k - 1;
    eu = 1'b0;
    ed = 1'b0;
    c  = 2'b00;
    if (p < 0 || h_rs[p]) begin
      m_busy = 1'b0;
    end else begin
      // Code seen by the FSM is the raw level three cycles back, zeroed
      // while a reset is still draining out of the synchroniser.
      if (p >= 2 && !h_rs[p-1] && !h_rs[p-2]) c = {h_up[p-2], h_dn[p-2]};
      if (!m_busy) begin
        if (c != 2'b00) begin
          m_busy   = 1'b1;
          m_locked = 1'b0;
          m_code   = c;
          m_len    = 1;
        end else if (h_tk[p] && h_en[p]) begin
          eu = 1'b1;
        end
      end else if (m_locked) begin
        if (c == 2'b00) m_busy = 1'b0;
      end else if (c != m_code) begin
        if (c == 2'b00 || m_len < D) m_busy = 1'b0;
        else m_locked = 1'b1;
      end else begin
        m_len++;
      end
      if (m_busy && !m_locked && c == m_code && pulse_due(m_len)) begin
        if (m_code == 2'b11) begin
          m_locked = 1'b1;
`ifdef ADJ_BOTH_CLEAR_EN
          eu = 1'b1;
          ed = 1'b1;
`endif
        end else begin
          eu = m_code[1];
          ed = m_code[0];
        end
      end
    end
    exp_q.push_back({eu, ed, m_busy});
  endtask

  // ---------------------------------------------------------------- driver
  task automatic step(input logic up, input logic dn, input logic tk,
                      input logic en, input logic rs);
    logic [2:0] e;
    i_btn_up   = up;
    i_btn_down = dn;
    i_tick     = tk;
    i_run_en   = en;
    i_rst      = rs;
    h_up[cyc]  = up;
    h_dn[cyc]  = dn;
    h_tk[cyc]  = tk;
    h_en[cyc]  = en;
    h_rs[cyc]  = rs;
    @(posedge i_clk);
    #1;
    cyc++;
    model_edge(cyc);
    e = exp_q.pop_front();
    chk("o_up", o_up, e[2]);
    chk("o_down", o_down, e[1]);
    chk("o_adjusting", o_adjusting, e[0]);
    if (o_up)   up_t.push_back(cyc - base);
    if (o_down) dn_t.push_back(cyc - base);
    if (adj_prev && !o_adjusting && adj_fall < 0) adj_fall = cyc - base;
    adj_prev = o_adjusting;
  endtask

  task automatic begin_scn();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    up_t.delete();
    dn_t.delete();
    base     = cyc;
    adj_fall = -1;
  endtask

  task automatic check_times(input string tag, input int got[$], input int exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk({tag, "_time"}, got[i], exp[i]);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int         none[$];
    logic [1:0] code;
    int         len;
    logic       en;
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    base     = 0;
    adj_fall = -1;
    adj_prev = 1'b0;
    m_busy   = 1'b0;
    m_locked = 1'b0;
    m_code   = 2'b00;
    m_len    = 0;
    for (int i = 0; i < HMAX; i++) begin
      h_up[i] = 1'b0; h_dn[i] = 1'b0; h_tk[i] = 1'b0; h_en[i] = 1'b0; h_rs[i] = 1'b0;
    end
    none.delete();

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Run tick forwarded while idle
    begin_scn();
    for (int n = 0; n < 20; n++) step(1'b0, 1'b0, n == 10, 1'b1, 1'b0);
    check_times("tick_up", up_t, '{11});
    check_times("tick_down", dn_t, none);

    // Short up press: one pulse, no repeat
    begin_scn();
    for (int n = 0; n < 40; n++) step(n >= 20 && n < 28, 1'b0, 1'b0, 1'b0, 1'b0);
    check_times("short_up", up_t, '{26});
    chk("short_adj_fall", adj_fall, 31);

    // Long down hold with auto-repeat
    begin_scn();
    for (int n = 0; n < 52; n++) step(1'b0, n < 40, 1'b0, 1'b0, 1'b0);
    check_times("hold_down", dn_t, '{6, 22, 26, 30, 34, 38, 42});
    check_times("hold_down_up", up_t, none);

    // Bouncing up button never debounces
    begin_scn();
    for (int n = 0; n < 20; n++) step(((n / 2) % 2) == 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 8; n++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_times("bounce_up", up_t, none);

    // Bounce with ticks mixed in: model decides which ticks survive
    begin_scn();
    for (int n = 0; n < 24; n++) step(((n / 2) % 2) == 0, 1'b0, (n % 3) == 0, 1'b1, 1'b0);

    // Both buttons together
    begin_scn();
    for (int n = 0; n < 45; n++) step(n >= 5 && n < 35, n >= 5 && n < 35, 1'b0, 1'b0, 1'b0);
`ifdef ADJ_BOTH_CLEAR_EN
    check_times("both_up", up_t, '{11});
    check_times("both_down", dn_t, '{11});
`else
    check_times("both_up", up_t, none);
    check_times("both_down", dn_t, none);
`endif

    // Reset during repeat, button still held
    begin_scn();
    for (int n = 0; n < 40; n++) step(1'b1, 1'b0, 1'b0, 1'b0, n == 25);
    check_times("rst_up", up_t, '{6, 22, 32});

    // Randomized traffic
    begin_scn();
    while (cyc < 6500) begin
      code = 2'($urandom_range(0, 3));
      len  = $urandom_range(1, 45);
      en   = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 15) == 0)
          step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 7) == 0, en, $urandom_range(0, 199) == 0);
        else
          step(code[1], code[0], $urandom_range(0, 7) == 0, en, $urandom_range(0, 199) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
